// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the fetch/execute sequencer and the rest of the 4-bit CPU.
// Ports: run/step control, ROM/RAM handshakes, decoder link, datapath strobes and status.
interface cpu_sequencer_if;
    logic        run;
    logic        step;
    logic        rom_ready;
    logic        ram_ready;
    logic [7:0]  instr_in;
    logic [12:0] ctrl_word;
    logic [11:0] jump_addr;
    logic        alu_c;
    logic        alu_z;

    logic [11:0] pc;
    logic        rom_req;
    logic [6:0]  decode_addr;
    logic [3:0]  instr_reg;
    logic [3:0]  oprnd_reg;
    logic        flag_c;
    logic        flag_z;
    logic        load_pc;
    logic        load_a;
    logic        load_out;
    logic [2:0]  alu_sel;
    logic        ram_cs;
    logic        ram_we;
    logic        oe_alu;
    logic        oe_in;
    logic        oe_oprnd;
    logic        halted;

    modport slave (
        input  run, step, rom_ready, ram_ready, instr_in,
        input  ctrl_word, jump_addr, alu_c, alu_z,
        output pc, rom_req, decode_addr, instr_reg, oprnd_reg,
        output flag_c, flag_z, load_pc, load_a, load_out, alu_sel,
        output ram_cs, ram_we, oe_alu, oe_in, oe_oprnd, halted
    );

    modport master (
        output run, step, rom_ready, ram_ready, instr_in,
        output ctrl_word, jump_addr, alu_c, alu_z,
        input  pc, rom_req, decode_addr, instr_reg, oprnd_reg,
        input  flag_c, flag_z, load_pc, load_a, load_out, alu_sel,
        input  ram_cs, ram_we, oe_alu, oe_in, oe_oprnd, halted
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: owns PC, instruction latch, C/Z flags and phase bit.
// Ports: clk, reset (async active-low), bus (slave side of cpu_sequencer_if).
module cpu_sequencer #(
    parameter logic [11:0] PC_RESET = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    cpu_sequencer_if.slave    bus
);

    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [3:0]  instr_q, instr_d;
    logic [3:0]  oprnd_q, oprnd_d;
    logic        fc_q, fc_d;
    logic        fz_q, fz_d;
    logic        step_q, step_d;

    logic        active;
    logic        phase;
    logic        done;
    logic [12:0] cw;

    assign active = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign phase  = (state_q == S_EXEC);

    // Decoder output is ignored while halted so every strobe stays low.
    assign cw = active ? bus.ctrl_word : 13'h0000;

    // FETCH completes on ROM data; EXEC completes at once unless it
    // touches RAM, in which case it waits for ram_ready.
    always_comb begin
        done = 1'b0;
        unique case (1'b1)
            state_q == S_FETCH: done = bus.rom_ready;
            state_q == S_EXEC:  done = !cw[5] || bus.ram_ready;
            default:            done = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (1'b1)
            state_q == S_HALT: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                    step_d  = 1'b0;
                end else if (bus.step) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
                end
            end
            state_q == S_FETCH: begin
                if (done) state_d = S_EXEC;
            end
            state_q == S_EXEC: begin
                if (done) begin
                    state_d = (bus.run && !step_q) ? S_FETCH : S_HALT;
                    step_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_HALT;
                step_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        oprnd_d = oprnd_q;
        fc_d    = fc_q;
        fz_d    = fz_q;
        if (done) begin
            if (cw[11])      pc_d = bus.jump_addr;
            else if (cw[12]) pc_d = pc_q + 12'd1;
            if (cw[9]) begin
                fc_d = bus.alu_c;
                fz_d = bus.alu_z;
            end
            if (state_q == S_FETCH) begin
                instr_d = bus.instr_in[7:4];
                oprnd_d = bus.instr_in[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_HALT;
            pc_q    <= PC_RESET;
            instr_q <= 4'h0;
            oprnd_q <= 4'h0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            step_q  <= step_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.rom_req     = (state_q == S_FETCH);
    assign bus.decode_addr = {instr_q, fc_q, fz_q, phase};
    assign bus.instr_reg   = instr_q;
    assign bus.oprnd_reg   = oprnd_q;
    assign bus.flag_c      = fc_q;
    assign bus.flag_z      = fz_q;
    assign bus.halted      = (state_q == S_HALT);

    // Pulses only in the completing cycle, never during RAM waits.
    assign bus.load_pc  = done && cw[11];
    assign bus.load_a   = done && cw[10];
    assign bus.load_out = done && cw[0];

    assign bus.alu_sel  = cw[8:6];
    assign bus.ram_cs   = cw[5];
    assign bus.ram_we   = cw[4];
    assign bus.oe_alu   = cw[3];
    assign bus.oe_in    = cw[2];
    assign bus.oe_oprnd = cw[1];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small decoder ROM model.
// Ports: none (top-level bench).
module tb_cpu_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cpu_sequencer_if bus ();

    cpu_sequencer #(.PC_RESET(12'h000)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model: phase 0 always increments PC; phase 1 per opcode.
    // 0 NOP, 3 STORE (RAM write), 5 ADD, 7 JMP.
    function automatic logic [12:0] dec(input logic [6:0] a);
        logic [3:0] op;
        op = a[6:3];
        if (!a[0]) return 13'h1000;
        case (op)
            4'h7:    return 13'h0800;
            4'h5:    return 13'h0642;
            4'h3:    return 13'h0779;
            default: return 13'h0000;
        endcase
    endfunction

    always_comb bus.ctrl_word = dec(bus.decode_addr);

    typedef struct {
        logic        run;
        logic        step;
        logic        romr;
        logic        ramr;
        logic [7:0]  ins;
        logic [11:0] ja;
        logic        c;
        logic        z;
        logic [8:0]  ex;
        logic [11:0] epc;
        logic [3:0]  eir;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic s, input logic rr, input logic mr,
        input logic [7:0] i, input logic [11:0] j, input logic c, input logic z,
        input logic [8:0] ex, input logic [11:0] epc, input logic [3:0] eir);
        vec_t v;
        v.run = r; v.step = s; v.romr = rr; v.ramr = mr;
        v.ins = i; v.ja = j; v.c = c; v.z = z;
        v.ex = ex; v.epc = epc; v.eir = eir;
        return v;
    endfunction

    vec_t tv[19];

    function automatic logic [8:0] obs();
        return {bus.halted, bus.rom_req, bus.load_pc, bus.load_a,
                bus.load_out, bus.ram_cs, bus.ram_we, bus.flag_c, bus.flag_z};
    endfunction

    function automatic logic [41:0] all_out();
        return {bus.pc, bus.rom_req, bus.decode_addr, bus.instr_reg,
                bus.oprnd_reg, bus.flag_c, bus.flag_z, bus.load_pc,
                bus.load_a, bus.load_out, bus.alu_sel, bus.ram_cs,
                bus.ram_we, bus.oe_alu, bus.oe_in, bus.oe_oprnd, bus.halted};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    localparam logic [41:0] RST_OUT = 42'h1;

    int pulses;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.run = 0; bus.step = 0; bus.rom_ready = 0; bus.ram_ready = 0;
        bus.instr_in = 8'h00; bus.jump_addr = 12'h000;
        bus.alu_c = 0; bus.alu_z = 0;

        //            run st rr mr ins    ja      c z  {h rq lp la lo cs we fc fz}  pc     ir
        tv[0]  = mk(0, 0, 0, 0, 8'h00, 12'h000, 0, 0, 9'b1_0_000_00_00, 12'h000, 4'h0);
        tv[1]  = mk(1, 0, 1, 1, 8'h00, 12'h000, 0, 0, 9'b1_0_000_00_00, 12'h000, 4'h0);
        tv[2]  = mk(1, 0, 1, 1, 8'h00, 12'h000, 0, 0, 9'b0_1_000_00_00, 12'h000, 4'h0);
        tv[3]  = mk(1, 0, 1, 1, 8'h00, 12'h000, 0, 0, 9'b0_0_000_00_00, 12'h001, 4'h0);
        tv[4]  = mk(1, 0, 1, 1, 8'h7A, 12'h000, 0, 0, 9'b0_1_000_00_00, 12'h001, 4'h0);
        tv[5]  = mk(1, 0, 1, 1, 8'h00, 12'h123, 0, 0, 9'b0_0_100_00_00, 12'h002, 4'h7);
        tv[6]  = mk(1, 0, 0, 1, 8'h00, 12'h000, 0, 0, 9'b0_1_000_00_00, 12'h123, 4'h7);
        tv[7]  = mk(1, 0, 1, 1, 8'h52, 12'h000, 0, 0, 9'b0_1_000_00_00, 12'h123, 4'h7);
        tv[8]  = mk(1, 0, 1, 1, 8'h00, 12'h000, 1, 0, 9'b0_0_010_00_00, 12'h124, 4'h5);
        tv[9]  = mk(1, 0, 1, 1, 8'h34, 12'h000, 0, 0, 9'b0_1_000_00_10, 12'h124, 4'h5);
        tv[10] = mk(1, 0, 1, 0, 8'h00, 12'h000, 0, 0, 9'b0_0_000_11_10, 12'h125, 4'h3);
        tv[11] = mk(1, 0, 1, 0, 8'h00, 12'h000, 0, 0, 9'b0_0_000_11_10, 12'h125, 4'h3);
        tv[12] = mk(0, 0, 1, 0, 8'h00, 12'h000, 0, 0, 9'b0_0_000_11_10, 12'h125, 4'h3);
        tv[13] = mk(0, 0, 1, 1, 8'h00, 12'h000, 0, 1, 9'b0_0_011_11_10, 12'h125, 4'h3);
        tv[14] = mk(0, 0, 1, 1, 8'h00, 12'h000, 0, 0, 9'b1_0_000_00_01, 12'h125, 4'h3);
        tv[15] = mk(0, 1, 1, 1, 8'h00, 12'h000, 0, 0, 9'b1_0_000_00_01, 12'h125, 4'h3);
        tv[16] = mk(0, 0, 1, 1, 8'h00, 12'h000, 0, 0, 9'b0_1_000_00_01, 12'h125, 4'h3);
        tv[17] = mk(1, 0, 1, 1, 8'h00, 12'h000, 0, 0, 9'b0_0_000_00_01, 12'h126, 4'h0);
        tv[18] = mk(0, 0, 1, 1, 8'h00, 12'h000, 0, 0, 9'b1_0_000_00_01, 12'h126, 4'h0);

        repeat (2) tick();
        #1;
        chk("reset_outputs", 64'(all_out()), 64'(RST_OUT));
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            tick();
            bus.run = tv[i].run;   bus.step = tv[i].step;
            bus.rom_ready = tv[i].romr; bus.ram_ready = tv[i].ramr;
            bus.instr_in = tv[i].ins; bus.jump_addr = tv[i].ja;
            bus.alu_c = tv[i].c;   bus.alu_z = tv[i].z;
            #1;
            chk($sformatf("v%0d_sig", i), 64'(obs()), 64'(tv[i].ex));
            chk($sformatf("v%0d_pc", i), 64'(bus.pc), 64'(tv[i].epc));
            chk($sformatf("v%0d_ir", i), 64'(bus.instr_reg), 64'(tv[i].eir));
        end

        // Back-to-back NOPs: two cycles per instruction, no load pulses.
        bus.run = 1; bus.rom_ready = 1; bus.ram_ready = 1;
        bus.instr_in = 8'h00;
        tick();
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (bus.load_pc || bus.load_a || bus.load_out) pulses++;
            tick();
        end
        #1;
        chk("nop_pulses", 64'(pulses), 64'd0);
        chk("nop_pc", 64'(bus.pc), 64'h12A);
        chk("nop_fetch", 64'(bus.rom_req), 64'd1);

        // Jump to 12'hFFF then wrap on the next increment.
        bus.instr_in = 8'h7A;
        tick();
        bus.jump_addr = 12'hFFF;
        #1;
        chk("jmp_daddr", 64'(bus.decode_addr), 64'h3B);
        tick();
        #1;
        chk("jmp_pc", 64'(bus.pc), 64'hFFF);
        bus.instr_in = 8'h00;
        tick();
        #1;
        chk("wrap_pc", 64'(bus.pc), 64'h000);

        // Reset during an EXEC wait aborts the instruction.
        tick();
        bus.instr_in = 8'h34;
        bus.ram_ready = 0;
        tick();
        tick();
        #1;
        chk("wait_cs", 64'({bus.ram_cs, bus.ram_we, bus.halted}), 64'b110);
        rst_n = 1'b0;
        bus.run = 0;
        #1;
        chk("rst_wait_out", 64'(all_out()), 64'(RST_OUT));
        bus.ram_ready = 1;
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        chk("rst_hold", 64'(all_out()), 64'(RST_OUT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
